hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Pipeline control block for the 5-stage RISC-V core. It covers the hazards that operand forwarding cannot resolve: load-use dependencies, multi-cycle data-memory waits and taken-branch redirects.
- It drives PC/IF-ID write enables, the ID/EX bubble, IF-ID and ID-EX flushes and a global pipeline hold.
- A small FSM extends load-use stalls for slow loads. Saturating counters record stall and flush events for performance monitoring.

Parameters:
- LOAD_USE_BUBBLES, 1: bubbles inserted per load-use hazard (legal range 1..7).
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- rs1_IFID  in  5  rs1 of the instruction in ID
- rs2_IFID  in  5  rs2 of the instruction in ID
- uses_rs1_IFID  in  1  ID instruction reads rs1
- uses_rs2_IFID  in  1  ID instruction reads rs2
- rd_IDEX  in  5  destination of the instruction in EX
- MemRead_IDEX  in  1  instruction in EX is a load
- branch_taken_EX  in  1  EX redirect (taken branch or jump); level signal, held while the instruction sits in EX
- mem_req_EXMEM  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- perf_clr  in  1  synchronous clear of both counters
- PCWrite  out  1  PC register enable
- IFIDWrite  out  1  IF/ID register enable
- IDEX_bubble  out  1  load ID/EX with a NOP
- IFID_flush  out  1  clear IF/ID to a NOP
- IDEX_flush  out  1  clear ID/EX to a NOP
- hold_all  out  1  freeze ID/EX, EX/MEM and MEM/WB
- stall_cycles  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of redirect events

Behaviour:
- Reset: one clock and reset only. Reset is synchronous and active-high.
  - Register state: state=RUN, bubble counter=0, stall_cycles=0, flush_count=0.
  - While rst=1 all control outputs are 0.
- mem_stall = mem_req_EXMEM & ~mem_ready.
- lu_hazard = MemRead_IDEX & (rd_IDEX != 0) & ((uses_rs1_IFID & rs1_IFID == rd_IDEX) | (uses_rs2_IFID & rs2_IFID == rd_IDEX)).
- Control outputs are Mealy (same cycle). Priority is evaluated top-down:
  1. mem_stall: hold_all=1, PCWrite=0, IFIDWrite=0; bubble and flushes are 0. State and bubble counter are frozen. A branch in EX is frozen with the pipeline, so its redirect is applied after release.
  2. branch_taken_EX: IFID_flush=1, IDEX_flush=1, PCWrite=1, IFIDWrite=1. The redirect overrides any load-use stall and forces state to RUN with counter 0.
  3. Load-use stall (state==LU_STALL, or state==RUN with lu_hazard): PCWrite=0, IFIDWrite=0, IDEX_bubble=1.
  4. Otherwise: PCWrite=1, IFIDWrite=1; all other outputs 0.
- FSM (advances only when mem_stall=0):
  - RUN to LU_STALL on lu_hazard with no branch, only if LOAD_USE_BUBBLES>1. The counter loads LOAD_USE_BUBBLES-1.
  - LU_STALL: decrement the counter each cycle. Return to RUN in the cycle the counter reaches 1, i.e. exactly LOAD_USE_BUBBLES bubbles in total.
  - lu_hazard is not re-evaluated while in LU_STALL.
  - After LU_STALL exits, ID re-checks against the new ID/EX contents (normally a bubble, so no hazard).
- With LOAD_USE_BUBBLES=1 the FSM never leaves RUN, and a hazard gives exactly one bubble cycle.
- A hazard against x0 never stalls. A load in EX whose rd matches an unused rs field never stalls.
- Counters:
  - stall_cycles +1 on every cycle with mem_stall or a load-use stall.
  - flush_count +1 on every non-frozen cycle with branch_taken_EX.
  - Both saturate at 2^CNT_W-1.
  - perf_clr zeroes them and wins over increment in the same cycle.
  - rst overrides everything.
- Reset mid-stall: the next cycle after rst deasserts starts in RUN; any pending bubbles are discarded.

Decomposition:
- Shared pipeline package holds:
  - FSM state enum (RUN, LU_STALL)
  - register-index width constant REG_AW=5
  - X0 constant
- One natural sub-module: sat_counter (parameter W; ports inc, clr, count), instantiated twice.

Test Plan:
- lw x5 in EX (rd=5, MemRead=1), ID uses rs1=5 -> exactly 1 cycle of PCWrite=0, IFIDWrite=0, IDEX_bubble=1, then normal flow; stall_cycles=1.
- LOAD_USE_BUBBLES=3, same hazard -> 3 consecutive bubble cycles with PC held; state returns to RUN; stall_cycles=3.
- Load hazard with rd=0, or matching rs2 with uses_rs2=0 -> no stall, all enables 1.
- branch_taken_EX in the same cycle as lu_hazard -> IFID_flush=IDEX_flush=1, PCWrite=1, bubble=0; flush_count=1.
- mem_req=1, mem_ready=0 for 4 cycles while in LU_STALL (counter=2) -> hold_all=1 for 4 cycles with the counter frozen, then the 2 remaining bubbles; stall_cycles increases by 6.
- CNT_W=4: 20 stall cycles -> stall_cycles stays at 15. perf_clr together with an increment -> 0. rst during LU_STALL -> RUN, counters 0.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// rtl/hazard_detection_unit_pkg.sv - shared pipeline types and constants for hazard control
package hazard_detection_unit_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] X0 = '0;

    typedef enum logic {
        RUN,
        LU_STALL
    } hdu_state_t;

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// rtl/hazard_detection_unit_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use, memory-wait and redirect control for the 5-stage core
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_IFID,
    input  logic [REG_AW-1:0] rs2_IFID,
    input  logic              uses_rs1_IFID,
    input  logic              uses_rs2_IFID,
    input  logic [REG_AW-1:0] rd_IDEX,
    input  logic              MemRead_IDEX,
    input  logic              branch_taken_EX,
    input  logic              mem_req_EXMEM,
    input  logic              mem_ready,
    input  logic              perf_clr,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IDEX_bubble,
    output logic              IFID_flush,
    output logic              IDEX_flush,
    output logic              hold_all,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [2:0] LU_INIT = 3'(LOAD_USE_BUBBLES - 1);

    hdu_state_t state;
    logic [2:0] bub_cnt;
    logic       mem_stall;
    logic       lu_hazard;
    logic       lu_active;
    logic       stall_inc;
    logic       flush_inc;

    assign mem_stall = mem_req_EXMEM & ~mem_ready;
    assign lu_hazard = MemRead_IDEX & (rd_IDEX != X0) &
                       ((uses_rs1_IFID & (rs1_IFID == rd_IDEX)) |
                        (uses_rs2_IFID & (rs2_IFID == rd_IDEX)));
    // While in LU_STALL the pending bubbles are committed; ID is not re-checked.
    assign lu_active = (state == LU_STALL) | ((state == RUN) & lu_hazard);
    assign stall_inc = ~rst & (mem_stall | (~branch_taken_EX & lu_active));
    assign flush_inc = ~rst & ~mem_stall & branch_taken_EX;

    always_comb begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        hold_all    = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                hold_all = 1'b1;
            end else if (branch_taken_EX) begin
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
                PCWrite    = 1'b1;
                IFIDWrite  = 1'b1;
            end else if (lu_active) begin
                IDEX_bubble = 1'b1;
            end else begin
                PCWrite   = 1'b1;
                IFIDWrite = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            bub_cnt <= '0;
        end else if (!mem_stall) begin
            if (branch_taken_EX) begin
                state   <= RUN;
                bub_cnt <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (lu_hazard && (LOAD_USE_BUBBLES > 1)) begin
                            state   <= LU_STALL;
                            bub_cnt <= LU_INIT;
                        end
                    end
                    LU_STALL: begin
                        if (bub_cnt == 3'd1) begin
                            state   <= RUN;
                            bub_cnt <= '0;
                        end else begin
                            bub_cnt <= bub_cnt - 3'd1;
                        end
                    end
                    default: begin
                        state   <= RUN;
                        bub_cnt <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clr   (perf_clr),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .clr   (perf_clr),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - randomized model-checked bench for hazard_detection_unit
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_IFID, rs2_IFID, rd_IDEX;
    logic       uses_rs1_IFID, uses_rs2_IFID, MemRead_IDEX;
    logic       branch_taken_EX, mem_req_EXMEM, mem_ready, perf_clr;

    logic        pc_a, ifid_a, bub_a, ff_a, ef_a, hold_a;
    logic [31:0] stall_a, flush_a;
    logic        pc_b, ifid_b, bub_b, ff_b, ef_b, hold_b;
    logic [3:0]  stall_b, flush_b;

    logic [5:0] ctrl_a, ctrl_b;
    assign ctrl_a = {pc_a, ifid_a, bub_a, ff_a, ef_a, hold_a};
    assign ctrl_b = {pc_b, ifid_b, bub_b, ff_b, ef_b, hold_b};

    int     checks = 0;
    int     failures = 0;
    int     pend_a = 0, pend_b = 0;
    longint sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.LOAD_USE_BUBBLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
        .uses_rs1_IFID(uses_rs1_IFID), .uses_rs2_IFID(uses_rs2_IFID),
        .rd_IDEX(rd_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .branch_taken_EX(branch_taken_EX), .mem_req_EXMEM(mem_req_EXMEM),
        .mem_ready(mem_ready), .perf_clr(perf_clr),
        .PCWrite(pc_a), .IFIDWrite(ifid_a), .IDEX_bubble(bub_a),
        .IFID_flush(ff_a), .IDEX_flush(ef_a), .hold_all(hold_a),
        .stall_cycles(stall_a), .flush_count(flush_a)
    );

    hazard_detection_unit #(.LOAD_USE_BUBBLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
        .uses_rs1_IFID(uses_rs1_IFID), .uses_rs2_IFID(uses_rs2_IFID),
        .rd_IDEX(rd_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .branch_taken_EX(branch_taken_EX), .mem_req_EXMEM(mem_req_EXMEM),
        .mem_ready(mem_ready), .perf_clr(perf_clr),
        .PCWrite(pc_b), .IFIDWrite(ifid_b), .IDEX_bubble(bub_b),
        .IFID_flush(ff_b), .IDEX_flush(ef_b), .hold_all(hold_b),
        .stall_cycles(stall_b), .flush_count(flush_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // pend = bubbles still owed after the current cycle; ctrl order is
    // {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, IDEX_flush, hold_all}
    task automatic model_step(input int lub, input int w, inout int pend,
                              inout longint sc, inout longint fc, output logic [5:0] ctrl);
        longint mx;
        bit     ms, haz, stalled;
        mx      = (longint'(1) << w) - 1;
        ctrl    = 6'b000000;
        stalled = 1'b0;
        if (rst) begin
            pend = 0;
            sc   = 0;
            fc   = 0;
        end else begin
            ms  = mem_req_EXMEM && !mem_ready;
            haz = MemRead_IDEX && (rd_IDEX != 0) &&
                  ((uses_rs1_IFID && (rs1_IFID == rd_IDEX)) ||
                   (uses_rs2_IFID && (rs2_IFID == rd_IDEX)));
            if (ms) begin
                ctrl    = 6'b000001;
                stalled = 1'b1;
            end else if (branch_taken_EX) begin
                ctrl = 6'b110110;
                pend = 0;
                if (fc < mx) fc++;
            end else if (pend > 0 || haz) begin
                ctrl    = 6'b001000;
                stalled = 1'b1;
                if (pend > 0) pend--;
                else pend = lub - 1;
            end else begin
                ctrl = 6'b110000;
            end
            if (stalled && sc < mx) sc++;
            if (perf_clr) begin
                sc = 0;
                fc = 0;
            end
        end
    endtask

    task automatic step();
        logic [5:0] ea, eb;
        @(negedge clk);
        chk("a_stall_cycles", stall_a, sc_a);
        chk("a_flush_count", flush_a, fc_a);
        chk("b_stall_cycles", stall_b, sc_b);
        chk("b_flush_count", flush_b, fc_b);
        model_step(1, 32, pend_a, sc_a, fc_a, ea);
        model_step(3, 4, pend_b, sc_b, fc_b, eb);
        chk("a_ctrl", ctrl_a, ea);
        chk("b_ctrl", ctrl_b, eb);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br,
                         input logic mq, input logic mrdy, input logic clr, input logic rs);
        rs1_IFID = r1; uses_rs1_IFID = u1; rs2_IFID = r2; uses_rs2_IFID = u2;
        rd_IDEX = rd; MemRead_IDEX = mr; branch_taken_EX = br;
        mem_req_EXMEM = mq; mem_ready = mrdy; perf_clr = clr; rst = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic mem_wait(input int n);
        for (int i = 0; i < n; i++) begin
            drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic lw_hazard();
        drive(5'd5, 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        chk("lit_reset_stall", stall_a, 0);
        idle(1);

        lw_hazard();
        idle(3);
        chk("lit_lu1_stall", stall_a, 1);
        chk("lit_lu3_stall", stall_b, 3);

        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_x0_no_stall", ctrl_a, 6'b110000);
        step();
        drive(5'd1, 1'b1, 5'd6, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_unused_rs2_no_stall", ctrl_b, 6'b110000);
        step();

        drive(5'd5, 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_branch_over_lu", ctrl_b, 6'b110110);
        step();
        idle(1);
        chk("lit_flush_count", flush_b, 1);

        lw_hazard();
        mem_wait(4);
        idle(2);
        chk("lit_memwait_a", stall_a, 6);
        chk("lit_memwait_b", stall_b, 10);

        mem_wait(20);
        chk("lit_sat_a", stall_a, 26);
        chk("lit_sat_b", stall_b, 15);

        drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk("lit_clr_wins", stall_b, 0);

        lw_hazard();
        drive(5'd5, 1'b1, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_run_after_rst", ctrl_b, 6'b110000);
        step();
        chk("lit_rst_clears", stall_b, 0);

        for (int i = 0; i < 4000; i++) begin
            drive(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 30),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 99) < 1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
